// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with prescaler, load/clear, terminal-count pulse,
// sticky overflow flag and combinational compare match.
module updown_mod_counter #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}},
  parameter bit               SATURATE = 1'b0,
  parameter int unsigned      PRESCALE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [WIDTH-1:0] cmp_val_i,
  input  logic             ovf_clr_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             ovf_o,
  output logic             match_o
);

  localparam int unsigned PscW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PscW-1:0] PscLast = PscW'(PRESCALE - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PscW-1:0]  psc_q, psc_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             tick;

  assign tick = en_i && (psc_q == PscLast);

  always_comb begin
    count_d = count_q;
    psc_d   = psc_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;

    if (en_i) begin
      psc_d = tick ? '0 : psc_q + 1'b1;
    end

    if (clear_i) begin
      count_d = '0;
      psc_d   = '0;
    end else if (load_i) begin
      count_d = (load_val_i > MAX) ? MAX : load_val_i;
      psc_d   = '0;
    end else if (tick) begin
      if (up_i) begin
        if (count_q == MAX) begin
          tc_d    = 1'b1;
          count_d = SATURATE ? MAX : '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          tc_d    = 1'b1;
          count_d = SATURATE ? '0 : MAX;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end

    // A boundary hit in the same cycle as ovf_clr keeps the flag set.
    if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
    if (tc_d) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      psc_q   <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      psc_q   <= psc_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc_q;
  assign ovf_o   = ovf_q;
  assign match_o = (count_q == cmp_val_i);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: three configurations share one stimulus stream and are
// checked against an arithmetic reference model, plus a vector table and directed sequences.
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, up = 1'b0, clr = 1'b0, ld = 1'b0, oc = 1'b0;
  logic [7:0] lv = 8'd0, cv = 8'd0;

  logic [7:0] cnt [3];
  logic       tc  [3];
  logic       ovf [3];
  logic       mt  [3];

  int total = 0;
  int bad   = 0;

  // Reference model state, one slot per DUT
  int m_cnt [3];
  int m_ph  [3];
  bit m_tc  [3];
  bit m_ovf [3];

  always #5 clk = ~clk;

  // 0: defaults (wrap 0..255), 1: MAX=9 saturating, 2: PRESCALE=4 wrap 0..255
  updown_mod_counter u_def (
    .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .clear_i(clr), .load_i(ld),
    .load_val_i(lv), .cmp_val_i(cv), .ovf_clr_i(oc),
    .count_o(cnt[0]), .tc_o(tc[0]), .ovf_o(ovf[0]), .match_o(mt[0])
  );

  updown_mod_counter #(.WIDTH(8), .MAX(8'd9), .SATURATE(1'b1), .PRESCALE(1)) u_sat (
    .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .clear_i(clr), .load_i(ld),
    .load_val_i(lv), .cmp_val_i(cv), .ovf_clr_i(oc),
    .count_o(cnt[1]), .tc_o(tc[1]), .ovf_o(ovf[1]), .match_o(mt[1])
  );

  updown_mod_counter #(.WIDTH(8), .PRESCALE(4)) u_psc (
    .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .clear_i(clr), .load_i(ld),
    .load_val_i(lv), .cmp_val_i(cv), .ovf_clr_i(oc),
    .count_o(cnt[2]), .tc_o(tc[2]), .ovf_o(ovf[2]), .match_o(mt[2])
  );

  function automatic int max_of(input int k);
    return (k == 1) ? 9 : 255;
  endfunction

  function automatic int psc_of(input int k);
    return (k == 2) ? 4 : 1;
  endfunction

  function automatic bit sat_of(input int k);
    return k == 1;
  endfunction

  function automatic void check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0; m_ph[k] = 0; m_tc[k] = 0; m_ovf[k] = 0;
    end
  endfunction

  // One rising edge of the reference behaviour, using currently driven inputs
  function automatic void model_step();
    for (int k = 0; k < 3; k++) begin
      m_tc[k] = 0;
      if (clr) begin
        m_cnt[k] = 0; m_ph[k] = 0;
      end else if (ld) begin
        m_cnt[k] = (int'(lv) > max_of(k)) ? max_of(k) : int'(lv);
        m_ph[k]  = 0;
      end else if (en) begin
        m_ph[k]++;
        if (m_ph[k] == psc_of(k)) begin
          int nxt;
          m_ph[k] = 0;
          nxt = up ? m_cnt[k] + 1 : m_cnt[k] - 1;
          if (nxt < 0 || nxt > max_of(k)) begin
            m_tc[k] = 1;
            if (sat_of(k)) nxt = m_cnt[k];
            else nxt = (nxt < 0) ? max_of(k) : 0;
          end
          m_cnt[k] = nxt;
        end
      end
      if (m_tc[k]) m_ovf[k] = 1;
      else if (oc) m_ovf[k] = 0;
    end
  endfunction

  function automatic void check_all();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("model count[%0d]", k), int'(cnt[k]), m_cnt[k]);
      check($sformatf("model tc[%0d]", k), int'(tc[k]), int'(m_tc[k]));
      check($sformatf("model ovf[%0d]", k), int'(ovf[k]), int'(m_ovf[k]));
      check($sformatf("model match[%0d]", k), int'(mt[k]), int'(m_cnt[k] == int'(cv)));
    end
  endfunction

  // Drive inputs after a falling edge, step the model on the rising edge, check on the next fall
  task automatic cycle(input logic e, input logic u, input logic c, input logic l,
                       input logic [7:0] lval, input logic [7:0] cval, input logic o);
    en = e; up = u; clr = c; ld = l; lv = lval; cv = cval; oc = o;
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    en = 0; up = 0; clr = 0; ld = 0; lv = 0; cv = 0; oc = 0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset count", int'(cnt[0]), 0);
    check("reset tc", int'(tc[0]), 0);
    check("reset ovf", int'(ovf[0]), 0);
    check("reset match", int'(mt[0]), 1);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       e, u, c, l, o;
    logic [7:0] lval;
    logic [7:0] x_cnt;
    logic       x_tc, x_ovf, x_match;
  } vec_t;

  vec_t vecs [10];

  initial begin
    // Vectors for the MAX=9 saturating instance, compare value 3 throughout
    vecs[0] = '{e:0, u:0, c:0, l:1, o:0, lval:8'd3,   x_cnt:8'd3, x_tc:0, x_ovf:0, x_match:1};
    vecs[1] = '{e:1, u:0, c:0, l:0, o:0, lval:8'd0,   x_cnt:8'd2, x_tc:0, x_ovf:0, x_match:0};
    vecs[2] = '{e:1, u:0, c:0, l:0, o:0, lval:8'd0,   x_cnt:8'd1, x_tc:0, x_ovf:0, x_match:0};
    vecs[3] = '{e:1, u:0, c:0, l:0, o:0, lval:8'd0,   x_cnt:8'd0, x_tc:0, x_ovf:0, x_match:0};
    vecs[4] = '{e:1, u:0, c:0, l:0, o:0, lval:8'd0,   x_cnt:8'd0, x_tc:1, x_ovf:1, x_match:0};
    vecs[5] = '{e:1, u:0, c:0, l:0, o:0, lval:8'd0,   x_cnt:8'd0, x_tc:1, x_ovf:1, x_match:0};
    vecs[6] = '{e:0, u:0, c:0, l:1, o:0, lval:8'd200, x_cnt:8'd9, x_tc:0, x_ovf:1, x_match:0};
    vecs[7] = '{e:0, u:0, c:0, l:0, o:1, lval:8'd0,   x_cnt:8'd9, x_tc:0, x_ovf:0, x_match:0};
    vecs[8] = '{e:1, u:1, c:0, l:0, o:0, lval:8'd0,   x_cnt:8'd9, x_tc:1, x_ovf:1, x_match:0};
    vecs[9] = '{e:1, u:1, c:1, l:1, o:0, lval:8'd5,   x_cnt:8'd0, x_tc:0, x_ovf:1, x_match:0};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].e, vecs[i].u, vecs[i].c, vecs[i].l, vecs[i].lval, 8'd3, vecs[i].o);
      check($sformatf("vec%0d count", i), int'(cnt[1]), int'(vecs[i].x_cnt));
      check($sformatf("vec%0d tc", i), int'(tc[1]), int'(vecs[i].x_tc));
      check($sformatf("vec%0d ovf", i), int'(ovf[1]), int'(vecs[i].x_ovf));
      check($sformatf("vec%0d match", i), int'(mt[1]), int'(vecs[i].x_match));
    end

    // Full wrap of the default instance
    do_reset();
    repeat (255) cycle(1, 1, 0, 0, 8'd0, 8'd0, 0);
    check("wrap pre count", int'(cnt[0]), 255);
    check("wrap pre tc", int'(tc[0]), 0);
    cycle(1, 1, 0, 0, 8'd0, 8'd0, 0);
    check("wrap count", int'(cnt[0]), 0);
    check("wrap tc", int'(tc[0]), 1);
    check("wrap ovf", int'(ovf[0]), 1);
    check("wrap match", int'(mt[0]), 1);
    cycle(1, 1, 0, 0, 8'd0, 8'd0, 0);
    check("post wrap count", int'(cnt[0]), 1);
    check("post wrap tc", int'(tc[0]), 0);
    check("post wrap ovf", int'(ovf[0]), 1);

    // Load beats a concurrent tick
    cycle(1, 1, 0, 1, 8'd5, 8'd0, 0);
    check("load vs tick", int'(cnt[0]), 5);
    cycle(1, 1, 0, 0, 8'd0, 8'd0, 0);
    check("count after load", int'(cnt[0]), 6);

    // ovf_clr on the wrap cycle loses to the set
    cycle(0, 1, 0, 1, 8'd255, 8'd0, 1);
    check("ovf cleared by clr", int'(ovf[0]), 0);
    cycle(1, 1, 0, 0, 8'd0, 8'd0, 1);
    check("ovf set wins", int'(ovf[0]), 1);
    cycle(0, 1, 0, 0, 8'd0, 8'd0, 1);
    check("ovf clr alone", int'(ovf[0]), 0);

    // Asynchronous reset between edges
    cycle(1, 0, 0, 0, 8'd0, 8'd0, 0);
    cycle(0, 0, 0, 1, 8'd37, 8'd0, 0);
    check("pre async count", int'(cnt[0]), 37);
    check("pre async ovf", int'(ovf[0]), 1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async count", int'(cnt[0]), 0);
    check("async tc", int'(tc[0]), 0);
    check("async ovf", int'(ovf[0]), 0);
    check("async match", int'(mt[0]), 1);
    @(negedge clk);
    rst = 1'b0;

    // Prescaler phase and en gaps
    do_reset();
    repeat (3) cycle(1, 1, 0, 0, 8'd0, 8'd0, 0);
    check("psc before tick", int'(cnt[2]), 0);
    cycle(1, 1, 0, 0, 8'd0, 8'd0, 0);
    check("psc first tick", int'(cnt[2]), 1);
    repeat (2) cycle(1, 1, 0, 0, 8'd0, 8'd0, 0);
    repeat (2) cycle(0, 1, 0, 0, 8'd0, 8'd0, 0);
    cycle(1, 1, 0, 0, 8'd0, 8'd0, 0);
    check("psc delayed", int'(cnt[2]), 1);
    cycle(1, 1, 0, 0, 8'd0, 8'd0, 0);
    check("psc second tick", int'(cnt[2]), 2);

    // Random stimulus against the model, direction held in runs to reach the bounds
    begin
      logic dir;
      dir = 1'b1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 63) == 0) dir = ~dir;
        if ($urandom_range(0, 499) == 0) begin
          do_reset();
        end else begin
          cycle(($urandom_range(0, 3) != 0), dir, ($urandom_range(0, 59) == 0),
                ($urandom_range(0, 39) == 0), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 12)), ($urandom_range(0, 9) == 0));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised up/down counter that generalises the existing 8-bit free-running up counter: configurable width, modulus, wrap or saturate mode, input prescaler, synchronous load/clear, terminal-count pulse, sticky overflow and compare match. It serves as the shared timebase and event-counting primitive for timers, baud dividers and test stimulus generators across the design.

## Interface
- WIDTH, 8: counter width in bits (1..32).
- MAX, 2**WIDTH-1: top count value; the range is 0..MAX, and MAX must not exceed 2**WIDTH-1.
- SATURATE, 0: 0 wraps at the bounds, 1 holds at the bounds.
- PRESCALE, 1: number of enabled cycles per count tick (1..65536).

- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  count enable; advances the prescaler.
- up  in  1  direction: 1 counts up, 0 counts down; sampled on the tick cycle.
- clear  in  1  synchronous clear of the counter and the prescaler.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  load value; values above MAX are clamped to MAX.
- cmp_val  in  WIDTH  compare value.
- ovf_clr  in  1  clears the sticky overflow flag.
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal-count pulse, registered.
- ovf  out  1  sticky overflow/underflow flag, registered.
- match  out  1  combinational (count == cmp_val).

## Operation
- Internal prescaler register psc uses width clog2(PRESCALE), or 1 bit minimum.
  - tick = en && (psc == PRESCALE-1).
  - When en=1 and there is no tick, psc increments. On a tick, psc returns to 0. When en=0, psc holds.
  - PRESCALE=1 gives tick = en.
- Priority per cycle: clear > load > tick > hold.
  - clear: count←0, psc←0, tc←0.
  - load: count←min(load_val, MAX), psc←0, tc←0.
  - tick with up=1:
    - count<MAX: count+1.
    - count==MAX: count←0 if SATURATE=0, otherwise it holds at MAX. tc←1.
  - tick with up=0:
    - count>0: count-1.
    - count==0: count←MAX if SATURATE=0, otherwise it holds at 0. tc←1.
  - Any other cycle: tc←0.
- In saturate mode, tc re-asserts on every tick attempted at the bound.
- ovf: set on any cycle where tc is being set; cleared by ovf_clr. If set and clear occur in the same cycle, set wins.
- Arithmetic uses WIDTH bits. MAX is compared exactly, and no intermediate value exceeds WIDTH bits.
- Reset-time outputs: count=0, psc=0, tc=0, ovf=0, and match = (cmp_val==0).

## Timing
- Latency is 1 cycle. count reflects a tick, load or clear on the rising edge that samples it.
- tc is high for exactly one cycle, concurrent with the post-boundary count value (0 after an up-wrap).
- Back-to-back ticks at a bound in saturate mode produce a continuous tc high.
- match follows count and cmp_val combinationally, with no extra latency.
- Reset asserted mid-operation forces all registers to reset values immediately, without waiting for a clock edge. Counting resumes on the first rising edge after deassertion, with the prescaler phase restarted from 0.
- A direction change takes effect on the next tick. There is no glitch and no skipped value.

## Test plan
- Wrap: defaults, reset high 2 cycles, then en=1, up=1. count goes 0,1,…,255,0. On the cycle count=0 after the wrap, tc=1 for one cycle, ovf=1 and stays 1.
- Saturating down: MAX=9, SATURATE=1. Load 3, then en=1, up=0. count goes 3,2,1,0,0,0. tc is 0 while leaving 1, then 1 on each tick at 0. Load 200 gives count=9.
- Prescaler: PRESCALE=4, en=1. count increments every 4th cycle. Dropping en for 2 cycles mid-phase delays the next increment by exactly 2 cycles.
- Priority: clear=1 and load=1 with load_val=5 in the same cycle gives count=0. load=1 together with a tick gives count=5, with no increment.
- Overflow flag: ovf_clr=1 on the same cycle as a wrap keeps ovf=1. ovf_clr alone on the next cycle gives ovf=0.
- Async reset: assert reset between clock edges with count=37. count, tc and ovf read 0 before the next edge, and match=1 when cmp_val=0.
